// File: rtl/axi_lite_slave_regfile_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared types for the AXI4-Lite slave register file:
//   resp_e      - AXI response encoding used on BRESP / RRESP
//   wr_state_e  - write channel FSM states
//   rd_state_e  - read channel FSM states
//   byte_off_bits() - number of address bits that select a byte within a word
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic {
        WR_COLLECT = 1'b0,
        WR_RESP    = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_VALID = 1'b1
    } rd_state_e;

    // Low address bits that address bytes inside one DATA_W word.
    function automatic int unsigned byte_off_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi_lite_slave_regfile_if.sv
// ---------------------------------------------------------------------------
// axi_lite_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) without clock/reset.
//   master modport - drives addresses, write data and response readies
//   slave  modport - drives address/data readies and the responses
// Parameters: DATA_W (32 or 64), ADDR_W.
// ---------------------------------------------------------------------------
interface axi_lite_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;

    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;

    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWVALID, input  AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );

endinterface

// File: rtl/axi_lite_slave_regfile_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile
// Register storage for the AXI4-Lite slave with byte-strobe merge.
// Ports:
//   i_clk, i_rst   - clock, synchronous active-high reset (clears all regs)
//   i_wr_en        - commit one write this cycle (index already range-checked)
//   i_wr_idx       - register index to write
//   i_wr_data      - write data
//   i_wr_strb      - byte-lane enables, one bit per byte of i_wr_data
//   i_rd_idx       - register index to read
//   o_rd_data      - combinational read data (0 for an index with no register)
//   o_reg_q        - all registers, flat; reg i at [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module axi_lite_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [IDX_W-1:0]           i_wr_idx,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic [DATA_W/8-1:0]        i_wr_strb,
    input  logic [IDX_W-1:0]           i_rd_idx,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic [NUM_REGS*DATA_W-1:0] o_reg_q
);

    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // NOTE: this array is reset because the whole register file is software-
    // visible state that must read as zero after reset; a plain data RAM would
    // be left unreset so it can map onto memory macros.
    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (i_wr_idx == IDX_W'(i)) begin
                    for (int b = 0; b < int'(STRB_W); b++) begin
                        if (i_wr_strb[b]) begin
                            r_regs[i][8*b +: 8] <= i_wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (i_rd_idx == IDX_W'(i)) begin
                o_rd_data = r_regs[i];
            end
        end
    end

    always_comb begin
        o_reg_q = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            o_reg_q[i*DATA_W +: DATA_W] = r_regs[i];
        end
    end

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regfile
// Parametrised AXI4-Lite slave register file.
// Parameters:
//   DATA_W   - data width, 32 or 64
//   ADDR_W   - AXI address width
//   NUM_REGS - number of DATA_W registers, 1 .. 2^(ADDR_W-log2(DATA_W/8))
// Ports:
//   ACLK    - clock
//   ARESET  - synchronous active-high reset; abandons any open transaction
//   s_axi   - AXI4-Lite slave bus (AW/W accepted independently, B, AR, R)
//   reg_q   - all registers, flat; reg i at [i*DATA_W +: DATA_W]
//   reg_wr  - one-cycle pulse per register, the cycle after it is written
// Out-of-range indices answer SLVERR; reads of them return zero.
// ---------------------------------------------------------------------------
module axi_lite_slave_regfile
    import axi_lite_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    axi_lite_if.slave                  s_axi,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_wr
);

    localparam int unsigned OFF_W  = byte_off_bits(DATA_W);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;
    localparam int unsigned STRB_W = DATA_W / 8;

    // -----------------------------------------------------------------------
    // Write channel
    // -----------------------------------------------------------------------
    wr_state_e           r_wr_state;
    wr_state_e           w_wr_state_nxt;
    logic                r_aw_held;
    logic                r_w_held;
    logic                w_aw_held_nxt;
    logic                w_w_held_nxt;
    logic                r_awready;
    logic                r_wready;
    logic [IDX_W-1:0]    r_aw_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    resp_e               r_bresp;
    logic [NUM_REGS-1:0] r_reg_wr;
    logic [NUM_REGS-1:0] w_reg_wr_nxt;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_commit;
    logic                w_wr_in_range;
    logic                w_wr_en;
    logic [IDX_W-1:0]    w_aw_idx_in;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [DATA_W-1:0]   w_wr_data;
    logic [STRB_W-1:0]   w_wr_strb;

    // Byte-offset address bits carry no information for word registers.
    logic                w_unused_addr_bits;
    assign w_unused_addr_bits = ^{s_axi.AWADDR[OFF_W-1:0], s_axi.ARADDR[OFF_W-1:0]};

    assign w_aw_idx_in = s_axi.AWADDR[ADDR_W-1:OFF_W];

    // The readies are registered, so they already encode "collecting and not
    // yet held"; a handshake is simply ready && valid.
    assign w_aw_hs = r_awready && s_axi.AWVALID;
    assign w_w_hs  = r_wready && s_axi.WVALID;

    // A handshake in this cycle counts as held, so a same-cycle AW+W (or the
    // second of the two arriving) commits on this very edge.
    assign w_commit = (r_wr_state == WR_COLLECT)
                   && (r_aw_held || w_aw_hs)
                   && (r_w_held || w_w_hs);

    assign w_wr_idx  = w_aw_hs ? w_aw_idx_in : r_aw_idx;
    assign w_wr_data = w_w_hs ? s_axi.WDATA : r_wdata;
    assign w_wr_strb = w_w_hs ? s_axi.WSTRB : r_wstrb;

    assign w_wr_in_range = 32'(w_wr_idx) < NUM_REGS;
    assign w_wr_en       = w_commit && w_wr_in_range;

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_held_nxt  = r_aw_held;
        w_w_held_nxt   = r_w_held;
        case (r_wr_state)
            WR_COLLECT: begin
                w_aw_held_nxt = r_aw_held || w_aw_hs;
                w_w_held_nxt  = r_w_held || w_w_hs;
                if (w_commit) begin
                    w_wr_state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi.BREADY) begin
                    w_aw_held_nxt  = 1'b0;
                    w_w_held_nxt   = 1'b0;
                    w_wr_state_nxt = WR_COLLECT;
                end
            end
        endcase
    end

    always_comb begin
        w_reg_wr_nxt = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_wr_en && (w_wr_idx == IDX_W'(i))) begin
                w_reg_wr_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state <= WR_COLLECT;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= OKAY;
            r_reg_wr   <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_aw_held  <= w_aw_held_nxt;
            r_w_held   <= w_w_held_nxt;
            // Readies follow the next state, so they drop on the accepting
            // edge and return the cycle after the B handshake.
            r_awready  <= (w_wr_state_nxt == WR_COLLECT) && !w_aw_held_nxt;
            r_wready   <= (w_wr_state_nxt == WR_COLLECT) && !w_w_held_nxt;
            if (w_aw_hs) begin
                r_aw_idx <= w_aw_idx_in;
            end
            if (w_w_hs) begin
                r_wdata <= s_axi.WDATA;
                r_wstrb <= s_axi.WSTRB;
            end
            if (w_commit) begin
                r_bresp <= w_wr_in_range ? OKAY : SLVERR;
            end
            r_reg_wr <= w_reg_wr_nxt;
        end
    end

    assign s_axi.AWREADY = r_awready;
    assign s_axi.WREADY  = r_wready;
    assign s_axi.BVALID  = (r_wr_state == WR_RESP);
    assign s_axi.BRESP   = r_bresp;
    assign reg_wr        = r_reg_wr;

    // -----------------------------------------------------------------------
    // Read channel
    // -----------------------------------------------------------------------
    rd_state_e         r_rd_state;
    rd_state_e         w_rd_state_nxt;
    logic              r_arready;
    logic [DATA_W-1:0] r_rdata;
    resp_e             r_rresp;

    logic              w_ar_hs;
    logic              w_rd_in_range;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_rd_data;

    assign w_rd_idx      = s_axi.ARADDR[ADDR_W-1:OFF_W];
    assign w_ar_hs       = r_arready && s_axi.ARVALID;
    assign w_rd_in_range = 32'(w_rd_idx) < NUM_REGS;

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_nxt = RD_VALID;
                end
            end
            RD_VALID: begin
                if (s_axi.RREADY) begin
                    w_rd_state_nxt = RD_IDLE;
                end
            end
        endcase
    end

    // Read data is captured from the storage before a same-edge commit lands,
    // so a read racing a write to the same register returns the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= OKAY;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= (w_rd_state_nxt == RD_IDLE);
            if (w_ar_hs) begin
                r_rdata <= w_rd_in_range ? w_rd_data : '0;
                r_rresp <= w_rd_in_range ? OKAY : SLVERR;
            end
        end
    end

    assign s_axi.ARREADY = r_arready;
    assign s_axi.RVALID  = (r_rd_state == RD_VALID);
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    axi_lite_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .i_clk     (ACLK),
        .i_rst     (ARESET),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (w_wr_data),
        .i_wr_strb (w_wr_strb),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data),
        .o_reg_q   (reg_q)
    );

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_regfile
// Directed bench for axi_lite_slave_regfile with DATA_W=32, ADDR_W=8,
// NUM_REGS=4 (byte addresses 0x00..0x0C in range, 0x10 and above not).
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_regfile;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 8;
    localparam int NUM_REGS = 4;

    logic                       ACLK = 1'b0;
    logic                       ARESET;
    logic [NUM_REGS*DATA_W-1:0] reg_q;
    logic [NUM_REGS-1:0]        reg_wr;

    int checks = 0;
    int errors = 0;

    axi_lite_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    axi_lite_slave_regfile #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .s_axi  (bus.slave),
        .reg_q  (reg_q),
        .reg_wr (reg_wr)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Same-cycle AW+W, waits (bounded) for BVALID, completes the B handshake.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
        bus.WDATA   = data;
        bus.WSTRB   = strb;
        bus.WVALID  = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        n = 0;
        while (!bus.BVALID && n < 20) begin
            tick();
            n++;
        end
        check("wr_bvalid_seen", 64'(bus.BVALID), 64'd1);
        resp = bus.BRESP;
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        n = 0;
        while (!bus.RVALID && n < 20) begin
            tick();
            n++;
        end
        check("rd_rvalid_seen", 64'(bus.RVALID), 64'd1);
        data = bus.RDATA;
        resp = bus.RRESP;
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0]  rd;
        logic [1:0]   rsp;
        logic [127:0] snap;

        ARESET      = 1'b1;
        bus.AWADDR  = '0;
        bus.AWVALID = 1'b0;
        bus.WDATA   = '0;
        bus.WSTRB   = '0;
        bus.WVALID  = 1'b0;
        bus.BREADY  = 1'b0;
        bus.ARADDR  = '0;
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_awready", 64'(bus.AWREADY), 64'd0);
        check("rst_wready",  64'(bus.WREADY),  64'd0);
        check("rst_arready", 64'(bus.ARREADY), 64'd0);
        check("rst_bvalid",  64'(bus.BVALID),  64'd0);
        check("rst_rvalid",  64'(bus.RVALID),  64'd0);
        check("rst_reg_wr",  64'(reg_wr),      64'd0);
        check("rst_reg_q_lo", reg_q[63:0],     64'd0);
        check("rst_reg_q_hi", reg_q[127:64],   64'd0);
        ARESET = 1'b0;
        tick();
        check("post_rst_awready", 64'(bus.AWREADY), 64'd1);
        check("post_rst_wready",  64'(bus.WREADY),  64'd1);
        check("post_rst_arready", 64'(bus.ARREADY), 64'd1);

        // ---- basic write/read: same-cycle AW+W to 0x04 ----
        bus.AWADDR  = 8'h04;
        bus.AWVALID = 1'b1;
        bus.WDATA   = 32'hDEADBEEF;
        bus.WSTRB   = 4'hF;
        bus.WVALID  = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        check("basic_bvalid",  64'(bus.BVALID),  64'd1);
        check("basic_bresp",   64'(bus.BRESP),   64'd0);
        check("basic_reg_wr",  64'(reg_wr),      64'b0010);
        check("basic_awready", 64'(bus.AWREADY), 64'd0);
        check("basic_wready",  64'(bus.WREADY),  64'd0);
        check("basic_reg1",    64'(reg_q[63:32]), 64'hDEADBEEF);
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check("basic_bvalid_clr", 64'(bus.BVALID),  64'd0);
        check("basic_pulse_once", 64'(reg_wr),      64'd0);
        check("basic_awready_up", 64'(bus.AWREADY), 64'd1);
        check("basic_wready_up",  64'(bus.WREADY),  64'd1);

        bus.ARADDR  = 8'h04;
        bus.ARVALID = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        check("basic_rvalid",  64'(bus.RVALID),  64'd1);
        check("basic_rdata",   64'(bus.RDATA),   64'hDEADBEEF);
        check("basic_rresp",   64'(bus.RRESP),   64'd0);
        check("basic_arready", 64'(bus.ARREADY), 64'd0);
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        check("basic_rvalid_clr", 64'(bus.RVALID),  64'd0);
        check("basic_arready_up", 64'(bus.ARREADY), 64'd1);

        // ---- strobe merge on reg2 ----
        axi_write(8'h08, 32'h11223344, 4'hF, rsp);
        check("strb_full_resp", 64'(rsp), 64'd0);
        axi_write(8'h08, 32'hAABBCCDD, 4'b0101, rsp);
        check("strb_part_resp", 64'(rsp), 64'd0);
        axi_read(8'h08, rd, rsp);
        check("strb_rdata", 64'(rd),  64'h11BB33DD);
        check("strb_rresp", 64'(rsp), 64'd0);

        // ---- zero strobe: pulse + OKAY, no data change ----
        bus.AWADDR  = 8'h08;
        bus.AWVALID = 1'b1;
        bus.WDATA   = 32'hFFFFFFFF;
        bus.WSTRB   = 4'h0;
        bus.WVALID  = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        check("strb0_reg_wr", 64'(reg_wr),        64'b0100);
        check("strb0_bresp",  64'(bus.BRESP),     64'd0);
        check("strb0_reg2",   64'(reg_q[95:64]),  64'h11BB33DD);
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;

        // ---- order independence: W first, AW three cycles later ----
        bus.WDATA  = 32'hCAFEF00D;
        bus.WSTRB  = 4'hF;
        bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        check("order_wready_low",   64'(bus.WREADY),  64'd0);
        check("order_awready_high", 64'(bus.AWREADY), 64'd1);
        check("order_no_bvalid0",   64'(bus.BVALID),  64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("order_no_bvalid", 64'(bus.BVALID), 64'd0);
        end
        bus.AWADDR  = 8'h08;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        check("order_bvalid", 64'(bus.BVALID), 64'd1);
        check("order_reg_wr", 64'(reg_wr),     64'b0100);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_bvalid",  64'(bus.BVALID),  64'd1);
            check("bp_bresp",   64'(bus.BRESP),   64'd0);
            check("bp_awready", 64'(bus.AWREADY), 64'd0);
            check("bp_wready",  64'(bus.WREADY),  64'd0);
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check("order_reg2",    64'(reg_q[95:64]), 64'hCAFEF00D);
        check("order_awready", 64'(bus.AWREADY),  64'd1);

        // ---- last register, byte-offset bits ignored (0x0F -> reg3) ----
        bus.AWADDR  = 8'h0F;
        bus.AWVALID = 1'b1;
        bus.WDATA   = 32'h0000ABCD;
        bus.WSTRB   = 4'hF;
        bus.WVALID  = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        check("last_reg_wr", 64'(reg_wr),      64'b1000);
        check("last_bresp",  64'(bus.BRESP),   64'd0);
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        axi_read(8'h0C, rd, rsp);
        check("last_rdata", 64'(rd), 64'h0000ABCD);

        // ---- out of range ----
        snap = reg_q;
        bus.AWADDR  = 8'h10;
        bus.AWVALID = 1'b1;
        bus.WDATA   = 32'h12345678;
        bus.WSTRB   = 4'hF;
        bus.WVALID  = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        check("oor_bvalid",   64'(bus.BVALID), 64'd1);
        check("oor_bresp",    64'(bus.BRESP),  64'd2);
        check("oor_reg_wr",   64'(reg_wr),     64'd0);
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check("oor_regs_lo",  reg_q[63:0],     snap[63:0]);
        check("oor_regs_hi",  reg_q[127:64],   snap[127:64]);
        check("oor_no_pulse", 64'(reg_wr),     64'd0);
        axi_read(8'h10, rd, rsp);
        check("oor_rdata", 64'(rd),  64'd0);
        check("oor_rresp", 64'(rsp), 64'd2);
        axi_read(8'hFC, rd, rsp);
        check("oor_top_rresp", 64'(rsp), 64'd2);

        // ---- concurrency: read of reg0 on the commit edge sees old value ----
        bus.AWADDR  = 8'h00;
        bus.AWVALID = 1'b1;
        bus.WDATA   = 32'h00000055;
        bus.WSTRB   = 4'hF;
        bus.WVALID  = 1'b1;
        bus.ARADDR  = 8'h00;
        bus.ARVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        bus.ARVALID = 1'b0;
        check("conc_rvalid", 64'(bus.RVALID),     64'd1);
        check("conc_bvalid", 64'(bus.BVALID),     64'd1);
        check("conc_rdata",  64'(bus.RDATA),      64'd0);
        check("conc_reg0",   64'(reg_q[31:0]),    64'h55);
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check("conc_bvalid_clr", 64'(bus.BVALID), 64'd0);
        check("rbp_rvalid1",     64'(bus.RVALID), 64'd1);
        check("rbp_rdata1",      64'(bus.RDATA),  64'd0);
        tick();
        check("rbp_rvalid2",     64'(bus.RVALID), 64'd1);
        check("rbp_rdata2",      64'(bus.RDATA),  64'd0);
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        check("rbp_rvalid_clr",  64'(bus.RVALID), 64'd0);
        axi_read(8'h00, rd, rsp);
        check("conc_new_rdata",  64'(rd), 64'h55);

        // ---- reset with both responses pending ----
        bus.AWADDR  = 8'h04;
        bus.AWVALID = 1'b1;
        bus.WDATA   = 32'h00000077;
        bus.WSTRB   = 4'hF;
        bus.WVALID  = 1'b1;
        bus.ARADDR  = 8'h08;
        bus.ARVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        bus.ARVALID = 1'b0;
        check("mid_bvalid", 64'(bus.BVALID), 64'd1);
        check("mid_rvalid", 64'(bus.RVALID), 64'd1);
        ARESET = 1'b1;
        tick();
        check("mid_rst_bvalid",  64'(bus.BVALID), 64'd0);
        check("mid_rst_rvalid",  64'(bus.RVALID), 64'd0);
        check("mid_rst_rdata",   64'(bus.RDATA),  64'd0);
        check("mid_rst_reg_wr",  64'(reg_wr),     64'd0);
        check("mid_rst_reg_lo",  reg_q[63:0],     64'd0);
        check("mid_rst_reg_hi",  reg_q[127:64],   64'd0);
        ARESET = 1'b0;
        tick();
        axi_write(8'h04, 32'h0BADCAFE, 4'hF, rsp);
        check("after_rst_bresp", 64'(rsp), 64'd0);
        axi_read(8'h04, rd, rsp);
        check("after_rst_rdata", 64'(rd),  64'h0BADCAFE);
        check("after_rst_rresp", 64'(rsp), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regfile.md
Name: axi_lite_slave_regfile

Overview:
Parametrised AXI4-Lite slave register file. It replaces the fixed 4×32-bit slave.
- Adds configurable data width, address width and register count.
- Accepts AW and W independently, in either order.
- Supports WSTRB byte-lane writes.
- Returns SLVERR for out-of-range addresses.
- Registered read data; all registers exported to the fabric.
- Sits between the AXI-Lite interconnect and peripheral control logic.

Parameters:
DATA_W, 32, data bus width; 32 or 64 only.
ADDR_W, 8, AXI address width.
NUM_REGS, 16, number of DATA_W registers; 1 to 2^(ADDR_W-log2(DATA_W/8)).

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous, active-high reset
AWADDR  in  ADDR_W  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte-lane write enables
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_W  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_W  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
reg_q  out  NUM_REGS*DATA_W  flat register contents; reg i at bits [i*DATA_W +: DATA_W]
reg_wr  out  NUM_REGS  one-cycle pulse for each register written

Behaviour:
Reset:
- Synchronous, active-high; takes effect on the ACLK edge where ARESET=1.
- AWREADY, WREADY, BVALID, RVALID, reg_wr = 0; BRESP, RRESP, RDATA = 0.
- All registers = 0; AW/W holding flags cleared.
- Reset mid-transaction abandons it: no partial write, no response issued.

Addressing:
- index = ADDR >> log2(DATA_W/8); low byte-offset bits are ignored.
- An index >= NUM_REGS is out of range.

Write path (states WR_COLLECT, WR_RESP):
- WR_COLLECT:
  - AWREADY = !aw_held; WREADY = !w_held.
  - An AW handshake latches AWADDR and sets aw_held. A W handshake latches WDATA/WSTRB and sets w_held.
  - AW and W may handshake in the same cycle or in either order.
- Commit:
  - Occurs on the edge where both are held, counting a same-cycle handshake as held.
  - In range: for each byte b with WSTRB[b]=1, reg[index][8b+7:8b] <= WDATA byte; reg_wr[index]=1 for the next cycle only.
  - WSTRB=0 still pulses reg_wr and returns OKAY.
  - Out of range: no register change, no pulse.
  - The next state is WR_RESP.
- WR_RESP:
  - BVALID=1; BRESP = OKAY (2'b00) or SLVERR (2'b10); AWREADY=WREADY=0.
  - BVALID rises exactly 1 cycle after the later of the two handshakes.
  - On BVALID&BREADY: clear held flags, go to WR_COLLECT; READYs are high the following cycle.
  - BVALID holds indefinitely while BREADY=0.

Read path (states RD_IDLE, RD_VALID):
- RD_IDLE:
  - ARREADY=1.
  - On ARVALID handshake, RDATA/RRESP are registered on that edge and the next state is RD_VALID.
  - In range: RDATA = reg[index], RRESP = OKAY. Out of range: RDATA = 0, RRESP = SLVERR.
- RD_VALID:
  - RVALID=1; ARREADY=0; RDATA/RRESP stable until RVALID&RREADY, then RD_IDLE.
- Read latency: RVALID 1 cycle after AR handshake. Maximum throughput is one read per 2 cycles.

Concurrency:
- Read and write paths are fully independent.
- Read handshake on the same edge as a commit to the same register returns the pre-write value.
- A read one or more cycles after the commit returns the new value.

Decomposition:
- Package axi_lite_pkg holds:
  - resp_e (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - wr_state_e, rd_state_e;
  - function for byte-offset bit count.
- Sub-module axi_lite_regfile holds:
  - register storage and strobe merge;
  - inputs: wr_en, wr_idx, wr_data, wr_strb, rd_idx;
  - outputs: combinational rd_data, reg_q.
- The top holds both channel FSMs and the response logic.

Test Plan:
- Basic write/read (DATA_W=32): AW 0x04 and W 0xDEADBEEF/4'hF in the same cycle -> BVALID next cycle, BRESP=00, reg_wr[1] pulse. Then AR 0x04 -> RVALID +1 cycle, RDATA=0xDEADBEEF, RRESP=00.
- Strobe merge: reg2=0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> readback 0x11BB33DD.
- Order independence: W first, AW 3 cycles later at 0x08 -> no BVALID until AW; BVALID 1 cycle after AW handshake. Hold BREADY=0 for 5 cycles -> BVALID, BRESP stable, AWREADY=WREADY=0.
- Out of range (NUM_REGS=4): write 0x10 -> BRESP=10, no reg_wr, registers unchanged. Read 0x10 -> RDATA=0, RRESP=10.
- Concurrency: write 0x55 to reg0 committing on the same edge as AR 0x00 -> RDATA=old value 0; next read -> 0x55. RREADY=0 backpressure -> RDATA held.
- Reset mid-operation: assert ARESET with BVALID=1 and RVALID=1 -> next cycle all VALIDs=0, reg_q=0. The first transaction after release completes normally.
